tile_blitter: RTL and testbench
===============================

# tile_blitter

Parametrised tile-drawing engine for the VGA frame path of the game display. It accepts one tile command (grid position, mode, colour) through a start/busy/done handshake. It then streams one pixel per clock to the VGA adapter's plot port: screen coordinate, colour and a plot strobe. It generalises the fixed 16×16 white/black tile datapath with configurable tile size, grid offset, colour depth, a draw mode, screen clipping and an explicit completion handshake.

## Interface
- TILE_W_LOG2, 4, log2 tile width in pixels
- TILE_H_LOG2, 4, log2 tile height in pixels
- GRID_BITS, 4, width of each tile-grid coordinate
- X_W, 8, screen x width
- Y_W, 7, screen y width
- Y_OFFSET, 8, vertical pixel offset of grid origin
- SCREEN_W, 160, visible width; pixels with x ≥ this are clipped
- SCREEN_H, 120, visible height; pixels with y ≥ this are clipped
- COLOUR_W, 3, colour width
- BG_COLOUR, 0, colour used by ERASE
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- tile_x  in  GRID_BITS  tile column
- tile_y  in  GRID_BITS  tile row
- mode  in  2  00 FILL, 01 ERASE, 10 OUTLINE, 11 treated as FILL
- colour_in  in  COLOUR_W  draw colour for FILL/OUTLINE
- busy  out  1  high in DRAW and DONE
- done  out  1  one-cycle pulse in DONE
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- colour  out  COLOUR_W  pixel colour
- plot  out  1  write strobe for current x_out/y_out/colour

## Operation
- States: IDLE → DRAW → DONE → IDLE.
- IDLE + start: latch tile_x, tile_y, mode, colour_in; clear the pixel counter; go to DRAW. In IDLE, start=0 holds the state.
- DRAW: scan row-major with column fastest, col 0..2^TILE_W_LOG2−1 and row 0..2^TILE_H_LOG2−1. Emit one pixel per cycle. After the last pixel (both counters at maximum), go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Pixel arithmetic:
  - x = (tile_x << TILE_W_LOG2) + col, computed at X_W+1 bits.
  - y = (tile_y << TILE_H_LOG2) + Y_OFFSET + row, computed at Y_W+1 bits.
  - x_out/y_out are truncated to X_W/Y_W.
- plot = 1 only when all of these hold: in DRAW, x < SCREEN_W, y < SCREEN_H (using the untruncated sums), and the mode condition is met.
  - OUTLINE: the pixel must be on the border, i.e. row or col equals 0 or its maximum.
  - FILL/ERASE: every pixel meets the mode condition.
- colour = BG_COLOUR for ERASE, otherwise the latched colour_in.
- Clipped or interior pixels still consume a cycle, so command duration is fixed.
- start while busy is ignored, with no queuing. Command inputs may change freely after acceptance.
- Reset asserted mid-operation: on the next edge the block is in IDLE, the counters are 0, and no done pulse is issued.

## Timing
- Reset values: busy=0, done=0, plot=0, x_out=0, y_out=0, colour=0, state IDLE.
- All outputs are registered.
- Let N = 2^(TILE_W_LOG2+TILE_H_LOG2). If start is sampled at edge 0:
  - pixel k (0..N−1) is valid on outputs after edge k+1;
  - done is high after edge N+1;
  - busy falls after edge N+2;
  - start is accepted again at edge N+2.
- Back-to-back commands: throughput is N+2 cycles per tile.
- When plot=0 in IDLE/DONE, x_out/y_out hold their last value.

## Structure
- Shared header blit_defs.vh holds:
  - mode encodings MODE_FILL, MODE_ERASE, MODE_OUTLINE;
  - state encodings;
  - default screen constants 160/120.
- Sub-module tile_scan_counter, a 2-D col/row counter with clear, enable and last flag, parametrised by TILE_W_LOG2/TILE_H_LOG2.
- FSM, latch registers and coordinate/clip/plot logic live in the top module.

## Test plan
- FILL, tile (2,3), colour 3'b101, defaults: first plot (32,56), last plot (47,71), 256 plot pulses, done one cycle after the last pixel (edge 257), all colour=101.
- OUTLINE, tile (0,0), colour 3'b010: exactly 60 plot pulses, at (0..15,8), (0..15,23), (0,9..22), (15,9..22); duration identical to FILL.
- ERASE with colour_in=3'b111: all 256 pixels plot with colour=000.
- Clip, tile (9,7): y base 120 ≥ SCREEN_H, so 0 plot pulses, busy for 258 cycles, done still pulses. Tile (9,0): x 144..159 all plotted.
- start re-asserted at cycle 50 of a command: ignored, single done. Reset at cycle 100: busy=0, plot=0, no done; a fresh start then completes normally.
- Parameter sweep TILE_W_LOG2=3, TILE_H_LOG2=2, tile (1,1): 32 pixels spanning x 8..15, y 12..15, done at edge 33.

Source files
------------

// File: rtl/tile_blitter_pkg.sv
// Shared definitions for the tile blitter: draw-mode encodings, FSM state
// encoding and the default visible-screen constants.
package tile_blitter_pkg;

    localparam int MODE_W = 2;

    // Draw modes. 2'b11 is not named and behaves as FILL.
    localparam logic [MODE_W-1:0] MODE_FILL    = 2'b00;
    localparam logic [MODE_W-1:0] MODE_ERASE   = 2'b01;
    localparam logic [MODE_W-1:0] MODE_OUTLINE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } blit_state_t;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/tile_blitter_if.sv
// Command + plot-port bundle of the tile blitter.
//   start/tile_x/tile_y/mode/colour_in : tile command, sampled only when idle
//   busy/done                          : command handshake back to the issuer
//   x_out/y_out/colour/plot            : pixel stream to the VGA adapter
// master = command issuer / pixel consumer, slave = the blitter.
interface tile_blitter_if #(
    parameter int GRID_BITS = 4,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 3
);
    import tile_blitter_pkg::*;

    logic                 start;
    logic [GRID_BITS-1:0] tile_x;
    logic [GRID_BITS-1:0] tile_y;
    logic [MODE_W-1:0]    mode;
    logic [COLOUR_W-1:0]  colour_in;
    logic                 busy;
    logic                 done;
    logic [X_W-1:0]       x_out;
    logic [Y_W-1:0]       y_out;
    logic [COLOUR_W-1:0]  colour;
    logic                 plot;

    modport master (
        output start, tile_x, tile_y, mode, colour_in,
        input  busy, done, x_out, y_out, colour, plot
    );

    modport slave (
        input  start, tile_x, tile_y, mode, colour_in,
        output busy, done, x_out, y_out, colour, plot
    );

endinterface

// File: rtl/tile_blitter_scan_counter.sv
// tile_scan_counter: 2-D col/row scan counter for one tile, column fastest.
//   clock, reset_n : clock, synchronous active-low reset
//   i_clear        : force both counters to 0 (has priority over i_enable)
//   i_enable       : advance one pixel
//   o_col, o_row   : current pixel inside the tile
//   o_last         : current pixel is the final one (both counters at max)
module tile_scan_counter #(
    parameter int TILE_W_LOG2 = 4,
    parameter int TILE_H_LOG2 = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   i_clear,
    input  logic                   i_enable,
    output logic [TILE_W_LOG2-1:0] o_col,
    output logic [TILE_H_LOG2-1:0] o_row,
    output logic                   o_last
);

    logic [TILE_W_LOG2-1:0] r_col;
    logic [TILE_H_LOG2-1:0] r_row;

    always_ff @(posedge clock) begin
        if (!reset_n || i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_enable) begin
            if (&r_col) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = (&r_col) && (&r_row);

endmodule

// File: rtl/tile_blitter.sv
// tile_blitter: draws one tile per command, one pixel per clock, into the
// VGA adapter's plot port. Supports FILL, ERASE (background colour) and
// OUTLINE (border only), with clipping against the visible screen.
//   clock, reset_n : clock, synchronous active-low reset
//   io_blit        : command handshake + pixel stream (slave side)
// Every output is registered; a command of N pixels occupies N+2 cycles
// regardless of clipping or mode.
module tile_blitter
    import tile_blitter_pkg::*;
#(
    parameter int TILE_W_LOG2 = 4,
    parameter int TILE_H_LOG2 = 4,
    parameter int GRID_BITS   = 4,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int Y_OFFSET    = 8,
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int COLOUR_W    = 3,
    parameter int BG_COLOUR   = 0
) (
    input  logic           clock,
    input  logic           reset_n,
    tile_blitter_if.slave  io_blit
);

    // Coordinates carry one extra bit so off-screen sums are not mistaken
    // for on-screen ones by the clip compare.
    localparam int XS = X_W + 1;
    localparam int YS = Y_W + 1;

    blit_state_t r_state, w_next_state;

    logic [GRID_BITS-1:0]   r_tile_x, r_tile_y;
    logic [MODE_W-1:0]      r_mode;
    logic [COLOUR_W-1:0]    r_colour_in;

    logic [TILE_W_LOG2-1:0] w_col;
    logic [TILE_H_LOG2-1:0] w_row;
    logic                   w_last;
    logic                   w_accept;

    logic [XS-1:0]          w_x;
    logic [YS-1:0]          w_y;
    logic                   w_border, w_mode_ok, w_on_screen, w_plot;
    logic [COLOUR_W-1:0]    w_colour;

    logic                   r_busy, r_done, r_plot;
    logic [X_W-1:0]         r_x_out;
    logic [Y_W-1:0]         r_y_out;
    logic [COLOUR_W-1:0]    r_colour;

    assign w_accept = (r_state == ST_IDLE) && io_blit.start;

    // FSM: state register
    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (io_blit.start) w_next_state = ST_DRAW;
            ST_DRAW: if (w_last)        w_next_state = ST_DONE;
            ST_DONE:                    w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    // Command latch; inputs are free to change once accepted.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_tile_x    <= '0;
            r_tile_y    <= '0;
            r_mode      <= MODE_FILL;
            r_colour_in <= '0;
        end else if (w_accept) begin
            r_tile_x    <= io_blit.tile_x;
            r_tile_y    <= io_blit.tile_y;
            r_mode      <= io_blit.mode;
            r_colour_in <= io_blit.colour_in;
        end
    end

    // Held at zero while idle so every DRAW starts from pixel (0,0).
    tile_scan_counter #(
        .TILE_W_LOG2 (TILE_W_LOG2),
        .TILE_H_LOG2 (TILE_H_LOG2)
    ) u_scan (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clear  (r_state == ST_IDLE),
        .i_enable (r_state == ST_DRAW),
        .o_col    (w_col),
        .o_row    (w_row),
        .o_last   (w_last)
    );

    assign w_x = (XS'(r_tile_x) << TILE_W_LOG2) + XS'(w_col);
    assign w_y = (YS'(r_tile_y) << TILE_H_LOG2) + YS'(Y_OFFSET) + YS'(w_row);

    assign w_border    = (w_col == '0) || (&w_col) || (w_row == '0) || (&w_row);
    assign w_mode_ok   = (r_mode != MODE_OUTLINE) || w_border;
    assign w_on_screen = (w_x < XS'(SCREEN_W)) && (w_y < YS'(SCREEN_H));
    assign w_plot      = (r_state == ST_DRAW) && w_on_screen && w_mode_ok;
    assign w_colour    = (r_mode == MODE_ERASE) ? COLOUR_W'(BG_COLOUR) : r_colour_in;

    // Registered outputs. busy rises with the accepting edge and drops one
    // edge after DONE, so a start on that edge keeps it high back-to-back.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_plot   <= 1'b0;
            r_x_out  <= '0;
            r_y_out  <= '0;
            r_colour <= '0;
        end else begin
            r_busy <= (r_state != ST_IDLE) || w_accept;
            r_done <= (r_state == ST_DONE);
            r_plot <= w_plot;
            if (r_state == ST_DRAW) begin
                r_x_out  <= w_x[X_W-1:0];
                r_y_out  <= w_y[Y_W-1:0];
                r_colour <= w_colour;
            end
        end
    end

    assign io_blit.busy   = r_busy;
    assign io_blit.done   = r_done;
    assign io_blit.plot   = r_plot;
    assign io_blit.x_out  = r_x_out;
    assign io_blit.y_out  = r_y_out;
    assign io_blit.colour = r_colour;

endmodule

// File: tb/tb_tile_blitter.sv
// Scoreboard bench for tile_blitter: stimulus pushes the pixels and done
// pulse it expects (with the edge each must appear after) into per-DUT
// queues; a negedge monitor pops and compares whatever the DUTs present.
// DUT 0 uses default parameters, DUT 1 uses 8x4 tiles.
module tb_tile_blitter;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    tile_blitter_if b0 ();
    tile_blitter_if b1 ();

    tile_blitter u0 (
        .clock   (clock),
        .reset_n (reset_n),
        .io_blit (b0.slave)
    );

    tile_blitter #(
        .TILE_W_LOG2 (3),
        .TILE_H_LOG2 (2)
    ) u1 (
        .clock   (clock),
        .reset_n (reset_n),
        .io_blit (b1.slave)
    );

    typedef struct {
        int cyc;
        int x;
        int y;
        int c;
    } pix_t;

    pix_t pq [2][$];
    int   dq [2][$];
    int   pcnt [2];
    int   ecnt   = 0;
    int   n_pass = 0;
    int   n_chk  = 0;

    always @(posedge clock) ecnt <= ecnt + 1;

    task automatic chk(input bit ok, input string msg);
        n_chk++;
        if (ok) n_pass++;
        else    $display("FAIL %s", msg);
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int d, input logic p, input int x, input int y,
                       input int c, input logic dn);
        pix_t e;
        int   de;
        if (p === 1'b1) begin
            pcnt[d]++;
            if (pq[d].size() == 0) begin
                chk(0, $sformatf("plot_extra d%0d: got plot at edge %0d (%0d,%0d) c%0d, expected no plot",
                                 d, ecnt, x, y, c));
            end else begin
                e = pq[d].pop_front();
                chk(e.cyc == ecnt && e.x == x && e.y == y && e.c == c,
                    $sformatf("pixel d%0d: got edge %0d (%0d,%0d) c%0d, expected edge %0d (%0d,%0d) c%0d",
                              d, ecnt, x, y, c, e.cyc, e.x, e.y, e.c));
            end
        end
        if (dn === 1'b1) begin
            if (dq[d].size() == 0) begin
                chk(0, $sformatf("done_extra d%0d: got done at edge %0d, expected none", d, ecnt));
            end else begin
                de = dq[d].pop_front();
                chk(de == ecnt, $sformatf("done_time d%0d: got edge %0d, expected edge %0d", d, ecnt, de));
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, b0.plot, int'(b0.x_out), int'(b0.y_out), int'(b0.colour), b0.done);
        mon(1, b1.plot, int'(b1.x_out), int'(b1.y_out), int'(b1.colour), b1.done);
    end

    // ---------------- reference model ----------------
    // Walks the tile with plain loops; coordinates wrap as unsigned sums of
    // one bit more than the output ports (x: 9 bits, y: 8 bits).
    task automatic model(input int d, input int tx, input int ty, input int md,
                         input int col, input int s, output int cnt);
        int   tw, th, w, h, x, y;
        bit   border;
        pix_t p;
        tw  = (d == 0) ? 4 : 3;
        th  = (d == 0) ? 4 : 2;
        w   = 1 << tw;
        h   = 1 << th;
        cnt = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                x      = (tx * w + c) % 512;
                y      = (ty * h + 8 + r) % 256;
                border = (r == 0) || (r == h - 1) || (c == 0) || (c == w - 1);
                if (x < 160 && y < 120 && (md != 2 || border)) begin
                    p.cyc = s + r * w + c + 1;
                    p.x   = x % 256;
                    p.y   = y % 128;
                    p.c   = (md == 1) ? 0 : col;
                    pq[d].push_back(p);
                    cnt++;
                end
            end
        end
        dq[d].push_back(s + w * h + 1);
    endtask

    // Drop expectations at or after edge r (a reset lands on that edge).
    task automatic flush(input int d, input int r);
        pix_t tp[$];
        int   td[$];
        for (int i = 0; i < pq[d].size(); i++) if (pq[d][i].cyc < r) tp.push_back(pq[d][i]);
        for (int i = 0; i < dq[d].size(); i++) if (dq[d][i] < r) td.push_back(dq[d][i]);
        pq[d] = tp;
        dq[d] = td;
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input int d, input bit st, input int tx, input int ty,
                         input int md, input int col);
        logic [3:0] gx, gy;
        logic [1:0] m;
        logic [2:0] c;
        gx = tx[3:0]; gy = ty[3:0]; m = md[1:0]; c = col[2:0];
        if (d == 0) begin
            b0.start = st; b0.tile_x = gx; b0.tile_y = gy; b0.mode = m; b0.colour_in = c;
        end else begin
            b1.start = st; b1.tile_x = gx; b1.tile_y = gy; b1.mode = m; b1.colour_in = c;
        end
    endtask

    task automatic drive_junk(input int d, input bit st);
        drive(d, st, $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 3), $urandom_range(0, 7));
    endtask

    function automatic logic get_busy(input int d);
        return (d == 0) ? b0.busy : b1.busy;
    endfunction

    function automatic logic get_plot(input int d);
        return (d == 0) ? b0.plot : b1.plot;
    endfunction

    function automatic logic get_done(input int d);
        return (d == 0) ? b0.done : b1.done;
    endfunction

    // Called at a negedge; returns at the negedge after edge s+N+1 (or
    // after edge s+idle extra), so back-to-back calls hit edge s+N+2.
    task automatic run_cmd(input int d, input int tx, input int ty, input int md,
                           input int col, input int poke_at, input int rst_at,
                           input bit idle_after);
        int s, n, cnt, p0;
        n  = (d == 0) ? 256 : 32;
        s  = ecnt + 1;
        p0 = pcnt[d];
        drive(d, 1'b1, tx, ty, md, col);
        model(d, tx, ty, md, col, s, cnt);
        @(negedge clock);
        drive_junk(d, 1'b0);
        chk(get_busy(d) === 1'b1, $sformatf("busy_rise d%0d: got %b, expected 1", d, get_busy(d)));
        chk(get_plot(d) === 1'b0, $sformatf("no_pix_yet d%0d: got plot %b, expected 0", d, get_plot(d)));
        for (int k = 1; k <= n + 1; k++) begin
            if (poke_at > 0 && k == poke_at)          drive_junk(d, 1'b1);
            else if (poke_at > 0 && k == poke_at + 1) drive_junk(d, 1'b0);
            if (k == rst_at) begin
                reset_n = 1'b0;
                flush(d, s + k);
            end
            @(negedge clock);
            if (k == rst_at) begin
                chk(get_busy(d) === 1'b0 && get_plot(d) === 1'b0 && get_done(d) === 1'b0,
                    $sformatf("reset_abort d%0d: got busy %b plot %b done %b, expected 0 0 0",
                              d, get_busy(d), get_plot(d), get_done(d)));
                reset_n = 1'b1;
                return;
            end
        end
        chk(get_busy(d) === 1'b1, $sformatf("busy_in_done d%0d: got %b, expected 1", d, get_busy(d)));
        chk(pcnt[d] - p0 == cnt, $sformatf("plot_count d%0d tile(%0d,%0d) mode %0d: got %0d, expected %0d",
                                           d, tx, ty, md, pcnt[d] - p0, cnt));
        if (idle_after) begin
            @(negedge clock);
            chk(get_busy(d) === 1'b0, $sformatf("busy_fall d%0d: got %b, expected 0", d, get_busy(d)));
        end
    endtask

    initial begin
        pcnt[0] = 0;
        pcnt[1] = 0;
        drive(0, 1'b0, 0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk(b0.busy === 1'b0 && b0.done === 1'b0 && b0.plot === 1'b0,
            $sformatf("reset_ctl d0: got busy %b done %b plot %b, expected 0 0 0", b0.busy, b0.done, b0.plot));
        chk(b0.x_out === 8'd0 && b0.y_out === 7'd0 && b0.colour === 3'd0,
            $sformatf("reset_data d0: got x %0d y %0d c %0d, expected 0 0 0", b0.x_out, b0.y_out, b0.colour));
        chk(b1.busy === 1'b0 && b1.done === 1'b0 && b1.plot === 1'b0,
            $sformatf("reset_ctl d1: got busy %b done %b plot %b, expected 0 0 0", b1.busy, b1.done, b1.plot));
        reset_n = 1'b1;
        @(negedge clock);

        run_cmd(0, 2, 3, 0, 5, 0, 0, 1);    // FILL
        run_cmd(0, 0, 0, 2, 2, 0, 0, 0);    // OUTLINE, followed back-to-back
        run_cmd(0, 5, 1, 1, 7, 0, 0, 1);    // ERASE
        run_cmd(0, 9, 7, 0, 3, 0, 0, 1);    // fully clipped
        run_cmd(0, 9, 0, 0, 6, 0, 0, 1);    // right edge
        run_cmd(0, 4, 4, 3, 1, 0, 0, 1);    // mode 11
        run_cmd(0, 15, 15, 0, 4, 0, 0, 1);  // y sum wraps
        run_cmd(0, 3, 2, 0, 4, 50, 0, 1);   // start while busy
        run_cmd(0, 6, 2, 2, 5, 0, 100, 0);  // reset mid-command
        run_cmd(0, 1, 5, 0, 2, 0, 0, 1);    // fresh command after reset
        for (int i = 0; i < 6; i++)
            run_cmd(0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                    $urandom_range(0, 7), 0, 0, bit'($urandom_range(0, 1)));

        run_cmd(1, 1, 1, 0, 3, 0, 0, 1);    // 8x4 tile
        for (int i = 0; i < 4; i++)
            run_cmd(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                    $urandom_range(0, 7), 0, 0, bit'($urandom_range(0, 1)));

        repeat (4) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk(pq[d].size() == 0, $sformatf("pix_drain d%0d: got %0d pixels never plotted, expected 0", d, pq[d].size()));
            chk(dq[d].size() == 0, $sformatf("done_drain d%0d: got %0d done pulses missing, expected 0", d, dq[d].size()));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
